// File: rtl/connect4_pkg.sv
// Shared types and width helper for the Connect-Four turn sequencer.
package connect4_pkg;

    typedef enum logic [1:0] {
        WAIT_MOVE = 2'd0,
        ISSUE     = 2'd1,
        OVER      = 2'd2
    } seq_state_t;

    localparam int PLAYER_NONE = 0;

    // Bits needed to encode n distinct values, never less than one.
    function automatic int width_of(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Per-bit rising-edge detector; history resets to ones so held buttons must be released first.
module btn_edge_detect #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist <= '1;
        else       hist <= level;
    end

    assign rise = level & ~hist;

endmodule

// File: rtl/turn_sequencer.sv
// Turn controller: arbitrates player confirms, issues moves to the board, tracks win/draw/timeout.
//   state     | meaning
//   WAIT_MOVE | waiting for the active player's confirm (timeout counter runs)
//   ISSUE     | move_req high until the board acks
//   OVER      | game finished, buttons ignored until new_game
module turn_sequencer
    import connect4_pkg::*;
#(
    parameter  int NUM_PLAYERS  = 2,
    parameter  int COLS         = 7,
    parameter  int ROWS         = 6,
    parameter  int TURN_TIMEOUT = 0,
    localparam int PW           = width_of(NUM_PLAYERS + 1),
    localparam int CW           = width_of(COLS),
    localparam int MW           = width_of(ROWS * COLS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_game,
    input  logic [CW-1:0]          column_select,
    input  logic [NUM_PLAYERS-1:0] confirm_move,
    input  logic [COLS-1:0]        column_full,
    input  logic                   move_ack,
    input  logic                   win_in,
    output logic                   move_req,
    output logic [CW-1:0]          move_col,
    output logic [PW-1:0]          current_player,
    output logic [MW-1:0]          moves_made,
    output logic                   board_clear,
    output logic                   illegal_move,
    output logic                   turn_timeout,
    output logic                   game_over,
    output logic                   draw,
    output logic [PW-1:0]          winner
);

    localparam int              TLOAD_I    = (TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0;
    localparam int              TW         = width_of(TLOAD_I + 1);
    localparam logic [TW-1:0]   TLOAD      = TW'(TLOAD_I);
    localparam int              CWE        = CW + 1;
    localparam logic [CWE-1:0]  COLS_LIM   = CWE'(COLS);
    localparam logic [MW-1:0]   DRAW_MOVES = MW'(ROWS * COLS);
    localparam logic [PW-1:0]   LAST_PLAYER = PW'(NUM_PLAYERS);
    localparam logic [PW-1:0]   NO_PLAYER  = PW'(PLAYER_NONE);

    seq_state_t       state_q, state_d;
    logic [PW-1:0]    player_q, player_d;
    logic [MW-1:0]    moves_q, moves_d;
    logic [CW-1:0]    col_q, col_d;
    logic [PW-1:0]    winner_q, winner_d;
    logic             draw_q, draw_d;
    logic             clear_q, clear_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [TW-1:0]    tmr_q, tmr_d;

    logic [NUM_PLAYERS-1:0] rise;
    logic                   active_edge;
    logic                   col_full_sel;
    logic                   bad_col;
    logic                   legal;
    logic [PW-1:0]          next_player;

    btn_edge_detect #(.WIDTH(NUM_PLAYERS)) u_edge (
        .clk   (clk),
        .reset (reset),
        .level (confirm_move),
        .rise  (rise)
    );

    always_comb begin
        active_edge = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (player_q == PW'(i + 1)) active_edge = rise[i];
        end
    end

    // Out-of-range selects never index column_full; the range check covers them.
    always_comb begin
        col_full_sel = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            if (column_select == CW'(i)) col_full_sel = column_full[i];
        end
    end

    assign bad_col     = ({1'b0, column_select} >= COLS_LIM) || col_full_sel;
    assign legal       = active_edge && !bad_col;
    assign next_player = (player_q == LAST_PLAYER) ? PW'(1) : player_q + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_MOVE;
            player_q  <= PW'(1);
            moves_q   <= '0;
            col_q     <= '0;
            winner_q  <= NO_PLAYER;
            draw_q    <= 1'b0;
            clear_q   <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            tmr_q     <= TLOAD;
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            moves_q   <= moves_d;
            col_q     <= col_d;
            winner_q  <= winner_d;
            draw_q    <= draw_d;
            clear_q   <= clear_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            tmr_q     <= tmr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        moves_d   = moves_q;
        col_d     = col_q;
        winner_d  = winner_q;
        draw_d    = draw_q;
        clear_d   = 1'b0;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        tmr_d     = tmr_q;

        if (new_game) begin
            state_d  = WAIT_MOVE;
            player_d = PW'(1);
            moves_d  = '0;
            winner_d = NO_PLAYER;
            draw_d   = 1'b0;
            clear_d  = 1'b1;
            tmr_d    = TLOAD;
        end else begin
            case (state_q)
                WAIT_MOVE: begin
                    // An illegal confirm does not restart the turn timer.
                    if (active_edge && bad_col) illegal_d = 1'b1;
                    if (legal) begin
                        col_d   = column_select;
                        state_d = ISSUE;
                        tmr_d   = TLOAD;
                    end else if (TURN_TIMEOUT != 0) begin
                        if (tmr_q == '0) begin
                            timeout_d = 1'b1;
                            player_d  = next_player;
                            tmr_d     = TLOAD;
                        end else begin
                            tmr_d = tmr_q - TW'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (move_ack) begin
                        moves_d = moves_q + MW'(1);
                        if (win_in) begin
                            state_d  = OVER;
                            winner_d = player_q;
                        end else if (moves_d == DRAW_MOVES) begin
                            state_d = OVER;
                            draw_d  = 1'b1;
                        end else begin
                            player_d = next_player;
                            state_d  = WAIT_MOVE;
                        end
                    end
                end
                OVER: ;
                default: state_d = WAIT_MOVE;
            endcase
        end
    end

    assign move_req       = (state_q == ISSUE);
    assign game_over      = (state_q == OVER);
    assign move_col       = col_q;
    assign current_player = player_q;
    assign moves_made     = moves_q;
    assign board_clear    = clear_q;
    assign illegal_move   = illegal_q;
    assign turn_timeout   = timeout_q;
    assign draw           = draw_q;
    assign winner         = winner_q;

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Parametrised turn controller for the Connect-Four game core, generalised to 2–4 players and any board size. It arbitrates per-player confirm buttons and rejects illegal columns before they reach the board. It issues each accepted move to the board/win-check logic over a req/ack handshake and enforces an optional per-turn timeout. It detects win and draw and supports restarting without a global reset. It sits between the button/switch front end and the board storage/win-detect block.

## Interface
Parameters:
- NUM_PLAYERS, 2 — players in rotation, legal 2..4.
- COLS, 7 — board columns.
- ROWS, 6 — board rows; draw limit is ROWS*COLS moves.
- TURN_TIMEOUT, 0 — cycles allowed per turn; 0 disables timeout.

Derived widths: PW = clog2(NUM_PLAYERS+1), CW = clog2(COLS), MW = clog2(ROWS*COLS+1).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high.
- new_game  in  1  synchronous restart request.
- column_select  in  CW  column chosen by the active player.
- confirm_move  in  NUM_PLAYERS  level button per player; bit i is player i+1.
- column_full  in  COLS  per-column full flags from the board.
- move_ack  in  1  board accepted move_req.
- win_in  in  1  move just applied makes four-in-a-row; valid with move_ack.
- move_req  out  1  move request to the board.
- move_col  out  CW  column of the pending move.
- current_player  out  PW  active player, 1..NUM_PLAYERS.
- moves_made  out  MW  accepted move count.
- board_clear  out  1  one-cycle pulse telling the board to clear.
- illegal_move  out  1  one-cycle pulse on a rejected confirm.
- turn_timeout  out  1  one-cycle pulse on a forfeited turn.
- game_over  out  1  game finished.
- draw  out  1  game finished with no winner.
- winner  out  PW  winning player; 0 = none.

## Operation
- States: WAIT_MOVE, ISSUE, OVER.
- Reset values: all outputs 0 except current_player = 1. State is WAIT_MOVE. Edge-detect history is all ones, so a button held through reset must be released before it counts.
- Confirm handling: rising edge per bit, detected internally. Only the edge on bit current_player-1 is acted on; other players' edges are ignored, but their history still updates.
- WAIT_MOVE, on an active edge:
  - If column_select >= COLS or column_full[column_select]: pulse illegal_move and stay. Timeout counter is not reset.
  - Otherwise: latch move_col and go to ISSUE.
- WAIT_MOVE timeout: when TURN_TIMEOUT != 0, the counter runs from 0 on entry. At TURN_TIMEOUT-1 with no legal edge: pulse turn_timeout, advance player, re-enter WAIT_MOVE. A legal edge in that same cycle takes priority over the timeout.
- ISSUE:
  - move_req is high; move_col and current_player are held stable until move_ack is sampled high.
  - On ack, moves_made increments, then:
    - win_in = 1: go to OVER, winner = current_player.
    - else, if the new moves_made equals ROWS*COLS: go to OVER, draw = 1, winner = 0.
    - else: advance player and go to WAIT_MOVE.
- Player advance wraps NUM_PLAYERS → 1.
- OVER: game_over = 1; all buttons ignored; current_player frozen.
- new_game: synchronous, highest priority below reset, acts in any state.
  - Next cycle: WAIT_MOVE, current_player = 1, moves_made = 0, game_over/draw/winner cleared.
  - move_req drops (any pending handshake is abandoned; a move_ack in the same cycle is discarded).
  - board_clear pulses for one cycle.

## Timing
- Confirm edge sampled at cycle n → move_req high at n+1.
- move_ack sampled at cycle n → move_req low, and current_player / game_over / winner / draw updated, at n+1.
- Illegal, timeout and board_clear pulses are exactly one cycle, registered, and appear the cycle after their cause.
- move_req stays asserted indefinitely without ack; the timeout counter does not run in ISSUE.
- Reset asserted mid-handshake drops move_req immediately (asynchronous).

## Structure
- Package connect4_pkg holds:
  - the state enum (WAIT_MOVE, ISSUE, OVER);
  - PLAYER_NONE = 0;
  - a width helper function for PW, CW and MW.
- Sub-module btn_edge_detect: NUM_PLAYERS-wide rising-edge detector, history reset to ones.

## Test plan
- NUM_PLAYERS=3, COLS=7: P1 confirms col 2, ack with win_in=0 → move_req one cycle after edge, move_col=2, current_player=2 one cycle after ack. P2 and P3 follow the same pattern; after P3, current_player wraps to 1.
- column_full[4]=1, P1 confirms col 4 → illegal_move single pulse, no move_req, current_player stays 1. Same result for column_select=7.
- TURN_TIMEOUT=10, no press → turn_timeout pulses 10 cycles after WAIT_MOVE entry, current_player=2. A legal press in cycle 10 → move accepted, no timeout.
- ROWS=1, COLS=2, two acks with win_in=0 → game_over=1, draw=1, winner=0, moves_made=2. Further confirms are ignored.
- Ack with win_in=1 from player 2 → game_over=1, winner=2. new_game → board_clear pulse, current_player=1, game_over=0, moves_made=0.
- Button held across reset deassert → no move until released and pressed again. new_game asserted during ISSUE together with move_ack → move_req drops, moves_made stays 0.
